// File: rtl/truth_table_sweeper_if.sv
// Control/result bus between a bench or self-test controller and truth_table_sweeper.
//   start          : begin a sweep (honoured only while the sweeper is idle)
//   expected       : golden truth table, bit i = required f for vector i
//   busy           : sweep in progress
//   done           : one-cycle pulse at the end of a sweep
//   pass           : last sweep had zero mismatches
//   fail_count     : mismatches in the last sweep (N_INPUTS+1 bits)
//   first_fail_idx : first mismatching vector (valid when fail_count != 0)
//   captured       : bit i = response sampled for vector i
// master = controller side, slave = sweeper side.
interface truth_table_sweeper_if #(
  parameter int unsigned N_INPUTS = 4
) ();
  localparam int unsigned NVec = 2 ** N_INPUTS;

  logic                start;
  logic [NVec-1:0]     expected;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   fail_count;
  logic [N_INPUTS-1:0] first_fail_idx;
  logic [NVec-1:0]     captured;

  modport master (
    output start, expected,
    input  busy, done, pass, fail_count, first_fail_idx, captured
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, fail_count, first_fail_idx, captured
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustively sweeps all 2**N_INPUTS input vectors of a combinational unit, holding each
// vector SETTLE_CYCLES cycles before sampling the response, and compares every response
// against a golden truth table.
// Ports:
//   clk_i     : rising-edge clock
//   reset_i   : synchronous, active-high reset
//   ctl_if    : control/result bus (slave modport), see truth_table_sweeper_if
//   dut_in_o  : vector driven to the unit, [N-1]=a ... [0]=d
//   dut_out_i : unit response f
// Optional build macro STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module truth_table_sweeper #(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  truth_table_sweeper_if.slave  ctl_if,
  output logic [N_INPUTS-1:0]   dut_in_o,
  input  logic                  dut_out_i
);
  localparam int unsigned NVec = 2 ** N_INPUTS;
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] IdxLast = {N_INPUTS{1'b1}};

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] idx_q, idx_d;
  logic [3:0]          settle_q, settle_d;
  logic [N_INPUTS:0]   fail_count_q, fail_count_d;
  logic [N_INPUTS-1:0] first_fail_q, first_fail_d;
  logic [NVec-1:0]     captured_q, captured_d;
  logic                pass_q, pass_d;
  logic                mismatch;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      settle_q     <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      captured_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      captured_q   <= captured_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    captured_d   = captured_q;
    pass_d       = pass_q;
    mismatch     = (dut_out_i != ctl_if.expected[idx_q]);

    case (state_q)
      StIdle: begin
        if (ctl_if.start) begin
          state_d      = StDrive;
          idx_d        = '0;
          settle_d     = '0;
          fail_count_d = '0;
          first_fail_d = '0;
          captured_d   = '0;
          pass_d       = 1'b0;
        end
      end
      StDrive: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSample: begin
        captured_d[idx_q] = dut_out_i;
        if (mismatch) begin
          fail_count_d = fail_count_q + 1'b1;
          if (fail_count_q == '0) first_fail_d = idx_q;
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch || idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
`else
        // Last vector exits to StDone so idx never wraps.
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
`endif
      end
      StDone: begin
        pass_d  = (fail_count_q == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dut_in_o = '0;
    if (state_q == StDrive || state_q == StSample) dut_in_o = idx_q;
  end

  assign ctl_if.busy           = (state_q == StDrive) || (state_q == StSample);
  assign ctl_if.done           = (state_q == StDone);
  assign ctl_if.pass           = pass_q;
  assign ctl_if.fail_count     = fail_count_q;
  assign ctl_if.first_fail_idx = first_fail_q;
  assign ctl_if.captured       = captured_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_dut_in, b_dut_in;
  logic       a_dut_out, b_dut_out;
  logic       a_fmode;  // 1: f = d, 0: f = 0
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_INPUTS(4)) a_if ();
  truth_table_sweeper_if #(.N_INPUTS(4)) b_if ();

  assign a_dut_out = a_fmode ? a_dut_in[0] : 1'b0;
  assign b_dut_out = b_dut_in[0];

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u_a (
    .clk_i     (clk),
    .reset_i   (reset),
    .ctl_if    (a_if.slave),
    .dut_in_o  (a_dut_in),
    .dut_out_i (a_dut_out)
  );

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(3)) u_b (
    .clk_i     (clk),
    .reset_i   (reset),
    .ctl_if    (b_if.slave),
    .dut_in_o  (b_dut_in),
    .dut_out_i (b_dut_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_dut_in"}, 32'(a_dut_in), 0);
    check({tag, "_busy"}, 32'(a_if.busy), 0);
    check({tag, "_done"}, 32'(a_if.done), 0);
    check({tag, "_pass"}, 32'(a_if.pass), 0);
    check({tag, "_fail_count"}, 32'(a_if.fail_count), 0);
    check({tag, "_first_fail"}, 32'(a_if.first_fail_idx), 0);
    check({tag, "_captured"}, 32'(a_if.captured), 0);
  endtask

  // Launches a sweep on u_a; k counts cycles since the edge that captured start.
  task automatic sweep_a(input int poke_at, input int reset_at, input bit chk_seq,
                         output int cycles);
    int k;
    @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    k = 0;
    cycles = -1;
    while (a_if.done !== 1'b1 && k < 200) begin
      if (chk_seq) begin
        check("a_seq_dut_in", 32'(a_dut_in), 32'(k / 2));
        check("a_seq_busy", 32'(a_if.busy), 1);
        check("a_seq_pass", 32'(a_if.pass), 0);
      end
      a_if.start = (k == poke_at);
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      k++;
    end
    a_if.start = 1'b0;
    cycles = k;
    check("a_done_busy", 32'(a_if.busy), 0);
    check("a_done_dut_in", 32'(a_dut_in), 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.expected = '0;
    b_if.expected = '0;
    a_fmode = 1'b1;
    repeat (2) @(negedge clk);
    check_a_zero("rst");
    check("rst_b_busy", 32'(b_if.busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_dut_in", 32'(a_dut_in), 0);

    // 1) f = d, matching table; stray start at +10 must be ignored
    a_if.expected = 16'hAAAA;
    sweep_a(10, -1, 1'b1, cyc);
    check("t1_latency", 32'(cyc), 32);
    check("t1_captured", 32'(a_if.captured), 32'hAAAA);
    @(negedge clk);
    check("t1_done_pulse", 32'(a_if.done), 0);
    check("t1_pass", 32'(a_if.pass), 1);
    check("t1_fail_count", 32'(a_if.fail_count), 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_if.done === 1'b1) pulses++;
    end
    check("t5_no_restart", 32'(pulses), 0);

    // 2) one mismatch at vector 0
    a_if.expected = 16'hAAAB;
    sweep_a(-1, -1, 1'b0, cyc);
`ifdef STOP_ON_FAIL_EN
    check("t2_latency", 32'(cyc), 2);
    check("t2_captured", 32'(a_if.captured), 0);
`else
    check("t2_latency", 32'(cyc), 32);
    check("t2_captured", 32'(a_if.captured), 32'hAAAA);
`endif
    @(negedge clk);
    check("t2_pass", 32'(a_if.pass), 0);
    check("t2_fail_count", 32'(a_if.fail_count), 1);
    check("t2_first_fail", 32'(a_if.first_fail_idx), 0);

    // 3) f = 0 against all-ones table
    a_fmode = 1'b0;
    a_if.expected = 16'hFFFF;
    sweep_a(-1, -1, 1'b0, cyc);
    @(negedge clk);
`ifdef STOP_ON_FAIL_EN
    check("t3_latency", 32'(cyc), 2);
    check("t3_fail_count", 32'(a_if.fail_count), 1);
`else
    check("t3_latency", 32'(cyc), 32);
    check("t3_fail_count", 32'(a_if.fail_count), 5'b10000);
`endif
    check("t3_first_fail", 32'(a_if.first_fail_idx), 0);
    check("t3_captured", 32'(a_if.captured), 0);
    check("t3_pass", 32'(a_if.pass), 0);

    // 4) reset during vector 7 with results partly accumulated
    a_fmode = 1'b1;
`ifdef STOP_ON_FAIL_EN
    a_if.expected = 16'hAAAA;
`else
    a_if.expected = 16'hAAAB;
`endif
    sweep_a(-1, 14, 1'b1, cyc);
    check_a_zero("t4_mid_reset");
    @(negedge clk);
    check_a_zero("t4_idle_after");

    // 6) fresh sweep after reset starts at vector 0 with full sequence check
    a_if.expected = 16'hAAAA;
    sweep_a(-1, -1, 1'b1, cyc);
    check("t6_latency", 32'(cyc), 32);
    @(negedge clk);
    check("t6_pass", 32'(a_if.pass), 1);
    check("t6_captured", 32'(a_if.captured), 32'hAAAA);

    // 5b) SETTLE_CYCLES = 3 instance
    b_if.expected = 16'hAAAA;
    @(negedge clk);
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    cyc = 0;
    while (b_if.done !== 1'b1 && cyc < 200) begin
      check("b_seq_dut_in", 32'(b_dut_in), 32'(cyc / 4));
      @(negedge clk);
      cyc++;
    end
    check("b_latency", 32'(cyc), 64);
    @(negedge clk);
    check("b_pass", 32'(b_if.pass), 1);
    check("b_captured", 32'(b_if.captured), 32'hAAAA);
    check("b_idle_dut_in", 32'(b_dut_in), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
